sha1_result_collector: RTL and testbench

Consumer side of the SHA1 core's result FIFO. Pops 32-bit result words through the `result_data_fifo_ren` / `result_data_empty` interface and assembles each run of five words into one 160-bit digest. Presents each digest to downstream logic (checker, host bridge) on a valid/ready handshake. Sits directly after the SHA1 core's result FIFO, opposite the core's result writer.

---
 rtl/sha1_result_collector.sv | 135 +++++++++++++
 tb/tb_sha1_result_collector.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_result_collector.sv
// sha1_result_collector: pops five 32-bit result words from the SHA1 result FIFO
// and presents them as one 160-bit digest on a valid/ready handshake.
// First-popped word lands in the MSBs.
// Optional build macro SHA1_RES_STAT_EN adds a 16-bit wrapping accepted-digest counter.
module sha1_result_collector #(
    parameter int RES_DATA_WIDTH = 32,
    parameter int DIGEST_WORDS   = 5,
    parameter int DIGEST_WIDTH   = RES_DATA_WIDTH * DIGEST_WORDS
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [RES_DATA_WIDTH-1:0] result_dout,
    input  logic                      result_data_empty,
    output logic                      result_data_fifo_ren,
    output logic [DIGEST_WIDTH-1:0]   digest_data,
    output logic                      digest_val,
    input  logic                      digest_ready
`ifdef SHA1_RES_STAT_EN
    ,
    output logic [15:0]               digest_cnt
`endif
);

    typedef enum logic [1:0] {FILL, DRAIN, OUT} state_t;

    localparam logic [2:0] WORDS_C = 3'(DIGEST_WORDS);
    localparam logic [2:0] LAST_C  = 3'(DIGEST_WORDS - 1);

    state_t                  state_q, state_d;
    logic [2:0]              rd_cnt_q, rd_cnt_d;
    logic [2:0]              cap_cnt_q, cap_cnt_d;
    logic                    ren_q, ren_d;
    logic                    cap_en_q, cap_en_d;
    logic [DIGEST_WIDTH-1:0] digest_q, digest_d;
    logic                    val_q, val_d;

    // State, counters, pop strobe, capture strobe and digest registers
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q   <= FILL;
            rd_cnt_q  <= '0;
            cap_cnt_q <= '0;
            ren_q     <= 1'b0;
            cap_en_q  <= 1'b0;
            digest_q  <= '0;
            val_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            ren_q     <= ren_d;
            cap_en_q  <= cap_en_d;
            digest_q  <= digest_d;
            val_q     <= val_d;
        end
    end

    // Next-state: issue pops in FILL, capture read data one cycle after each pop,
    // present the digest in OUT until accepted
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        cap_cnt_d = cap_cnt_q;
        ren_d     = 1'b0;
        cap_en_d  = ren_q;
        digest_d  = digest_q;
        val_d     = val_q;

        if (cap_en_q) begin
            digest_d[DIGEST_WIDTH-1-RES_DATA_WIDTH*int'(cap_cnt_q) -: RES_DATA_WIDTH] = result_dout;
            cap_cnt_d = cap_cnt_q + 3'd1;
        end

        case (state_q)
            FILL: begin
                if (!result_data_empty && (rd_cnt_q < WORDS_C)) begin
                    ren_d    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 3'd1;
                    if (rd_cnt_q == LAST_C) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cap_en_q && (cap_cnt_q == LAST_C)) begin
                    state_d = OUT;
                    val_d   = 1'b1;
                end
            end
            OUT: begin
                if (val_q && digest_ready) begin
                    val_d     = 1'b0;
                    cap_cnt_d = '0;
                    state_d   = FILL;
                    // First pop of the next digest is decided on the accept edge;
                    // the strobe itself only appears once back in FILL, which gives
                    // the 7-cycle digest period.
                    if (!result_data_empty) begin
                        ren_d    = 1'b1;
                        rd_cnt_d = 3'd1;
                    end else begin
                        rd_cnt_d = '0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign result_data_fifo_ren = ren_q;
    assign digest_data          = digest_q;
    assign digest_val           = val_q;

`ifdef SHA1_RES_STAT_EN
    logic [15:0] digest_cnt_q;

    // Count accepted digests, wrapping at 16 bits
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            digest_cnt_q <= '0;
        end else if (val_q && digest_ready) begin
            digest_cnt_q <= digest_cnt_q + 16'd1;
        end
    end

    assign digest_cnt = digest_cnt_q;
`else
    // No accepted-digest counter in this build.
`endif

    // Reads issued never exceed one digest, and captures never outrun reads
    assert property (@(posedge sys_clk) disable iff (!sys_rst)
        (rd_cnt_q <= WORDS_C) && (cap_cnt_q <= rd_cnt_q));

endmodule

// File: tb/tb_sha1_result_collector.sv
// Bench for sha1_result_collector: FIFO model with registered read data,
// table-driven digest vectors plus hand-written timing, backpressure, reset,
// random-ready scoreboard and (with SHA1_RES_STAT_EN) counter checks.
module tb_sha1_result_collector;

    logic         sys_clk;
    logic         sys_rst;
    logic [31:0]  result_dout;
    logic         result_data_empty;
    logic         result_data_fifo_ren;
    logic [159:0] digest_data;
    logic         digest_val;
    logic         digest_ready;
`ifdef SHA1_RES_STAT_EN
    logic [15:0]  digest_cnt;
`endif

    sha1_result_collector #(
        .RES_DATA_WIDTH(32),
        .DIGEST_WORDS(5)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .result_dout(result_dout),
        .result_data_empty(result_data_empty),
        .result_data_fifo_ren(result_data_fifo_ren),
        .digest_data(digest_data),
        .digest_val(digest_val),
        .digest_ready(digest_ready)
`ifdef SHA1_RES_STAT_EN
        ,
        .digest_cnt(digest_cnt)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // FIFO model: pop sampled on the clock edge, data registered (valid the
    // cycle after ren). Empty already accounts for a pop in flight.
    logic [31:0] fmem [256];
    int          wp = 0;
    int          rp = 0;
    int          pops = 0;
    bit          underflow = 1'b0;

    assign result_data_empty = ((wp - rp) <= (result_data_fifo_ren ? 1 : 0));

    always @(posedge sys_clk) begin
        if (!sys_rst) begin
            rp          <= wp;
            result_dout <= '0;
        end else if (result_data_fifo_ren) begin
            pops <= pops + 1;
            if (wp == rp) underflow <= 1'b1;
            else begin
                result_dout <= fmem[rp & 255];
                rp          <= rp + 1;
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fmem[wp & 255] = w;
        wp++;
    endtask

    task automatic wait_val(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge sys_clk);
            if (digest_val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [31:0]  w [5];
        int           gap_pos;
        int           gap_len;
        int           rdy_delay;
        logic [159:0] exp;
    } vec_t;

    vec_t vec [4];

    initial begin : main
        bit           ok;
        bit           stable;
        int           p0;
        int           k;
        logic [15:0]  ren_hist;
        logic [15:0]  val_hist;
        logic [159:0] hold;
        logic [159:0] d1;
        logic [159:0] d2;
        logic [159:0] exp;
        logic [31:0]  rw [50];

        vec[0].w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        vec[0].gap_pos = 2; vec[0].gap_len = 4; vec[0].rdy_delay = 0;
        vec[0].exp = 160'h11111111_22222222_33333333_44444444_55555555;
        vec[1].w = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h00000000};
        vec[1].gap_pos = 0; vec[1].gap_len = 0; vec[1].rdy_delay = 3;
        vec[1].exp = 160'hDEADBEEF_01234567_89ABCDEF_FFFFFFFF_00000000;
        vec[2].w = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h80000000};
        vec[2].gap_pos = 4; vec[2].gap_len = 2; vec[2].rdy_delay = 0;
        vec[2].exp = 160'h00000001_00000002_00000003_00000004_80000000;
        vec[3].w = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hC3C3C3C3, 32'h3C3C3C3C, 32'h0F0F0F0F};
        vec[3].gap_pos = 1; vec[3].gap_len = 6; vec[3].rdy_delay = 1;
        vec[3].exp = 160'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C_0F0F0F0F;

        // Reset values
        sys_rst = 1'b0;
        digest_ready = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("rst_ren", result_data_fifo_ren, 0);
        chk("rst_val", digest_val, 0);
        chk("rst_data", digest_data, 0);
`ifdef SHA1_RES_STAT_EN
        chk("rst_cnt", digest_cnt, 0);
`endif
        sys_rst = 1'b1;
        @(negedge sys_clk);

        // Back-to-back with ready tied high: cycle-exact ren/val timing, 7-cycle period
        push(32'h67452301); push(32'hEFCDAB89); push(32'h98BADCFE);
        push(32'h10325476); push(32'hC3D2E1F0);
        for (int i = 1; i <= 5; i++) push(32'hA0000000 + 32'(i));
        digest_ready = 1'b1;
        ren_hist = '0; val_hist = '0; d1 = '0; d2 = '0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge sys_clk);
            ren_hist[c] = result_data_fifo_ren;
            val_hist[c] = digest_val;
            if (c == 7)  d1 = digest_data;
            if (c == 14) d2 = digest_data;
        end
        chk("b2b_ren_pattern", ren_hist, 16'h1F3E);
        chk("b2b_val_pattern", val_hist, 16'h4080);
        chk("b2b_digest1", d1, 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0);
        chk("b2b_digest2", d2, 160'hA0000001_A0000002_A0000003_A0000004_A0000005);
        @(negedge sys_clk);
        digest_ready = 1'b0;
        chk("b2b_val_clear", digest_val, 0);

        // Table vectors: gaps in the FIFO and delayed ready
        for (int v = 0; v < 4; v++) begin
            p0 = pops;
            digest_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (i == vec[v].gap_pos && vec[v].gap_len > 0)
                    repeat (vec[v].gap_len) @(negedge sys_clk);
                push(vec[v].w[i]);
            end
            wait_val(60, ok);
            chk("vec_val_seen", ok, 1);
            chk("vec_data", digest_data, vec[v].exp);
            chk("vec_pops", pops - p0, 5);
            hold = digest_data;
            stable = 1'b1;
            for (int i = 0; i < vec[v].rdy_delay; i++) begin
                @(negedge sys_clk);
                if (digest_data !== hold || result_data_fifo_ren || !digest_val) stable = 1'b0;
            end
            chk("vec_hold", stable, 1);
            digest_ready = 1'b1;
            @(negedge sys_clk);
            digest_ready = 1'b0;
            chk("vec_val_clear", digest_val, 0);
        end

        // Backpressure: ten words queued, ready low for 10 cycles
        for (int i = 1; i <= 10; i++) push(32'hB0000000 + 32'(i));
        wait_val(60, ok);
        chk("bp_val_seen", ok, 1);
        chk("bp_digest1", digest_data, 160'hB0000001_B0000002_B0000003_B0000004_B0000005);
        hold = digest_data;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (digest_data !== hold || result_data_fifo_ren || !digest_val) stable = 1'b0;
        end
        chk("bp_hold_no_pop", stable, 1);
        digest_ready = 1'b1;
        @(negedge sys_clk);
        chk("bp_accept_clear", digest_val, 0);
        wait_val(60, ok);
        chk("bp_val2_seen", ok, 1);
        chk("bp_digest2", digest_data, 160'hB0000006_B0000007_B0000008_B0000009_B000000A);
        @(negedge sys_clk);
        digest_ready = 1'b0;

        // Reset after three captures: outputs clear asynchronously, no stale words afterwards
        for (int i = 1; i <= 5; i++) push(32'hC0000000 + 32'(i));
        repeat (5) @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        #1;
        chk("mid_rst_ren", result_data_fifo_ren, 0);
        chk("mid_rst_val", digest_val, 0);
        chk("mid_rst_data", digest_data, 0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        for (int i = 1; i <= 5; i++) push(32'hD0000000 + 32'(i));
        digest_ready = 1'b1;
        wait_val(60, ok);
        chk("post_rst_val_seen", ok, 1);
        chk("post_rst_digest", digest_data, 160'hD0000001_D0000002_D0000003_D0000004_D0000005);
        @(negedge sys_clk);
        digest_ready = 1'b0;

        // Ten digests, ready toggling randomly, against a scoreboard
        sys_rst = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rw[i] = 32'h5A000000 ^ (32'(i) * 32'h00010203);
            push(rw[i]);
        end
        k = 0;
        for (int c = 0; c < 1500 && k < 10; c++) begin
            @(negedge sys_clk);
            digest_ready = 1'($urandom_range(0, 1));
            if (digest_val && digest_ready) begin
                for (int j = 0; j < 5; j++) exp[159-32*j -: 32] = rw[5*k+j];
                chk("rand_digest", digest_data, exp);
                k++;
            end
        end
        chk("rand_count", k, 10);
        @(negedge sys_clk);
        digest_ready = 1'b0;
`ifdef SHA1_RES_STAT_EN
        chk("stat_cnt_10", digest_cnt, 10);

        // Counter wrap
        force dut.digest_cnt_q = 16'hFFFF;
        @(negedge sys_clk);
        release dut.digest_cnt_q;
        @(negedge sys_clk);
        chk("stat_cnt_forced", digest_cnt, 16'hFFFF);
        for (int i = 1; i <= 5; i++) push(32'hE0000000 + 32'(i));
        digest_ready = 1'b1;
        wait_val(60, ok);
        chk("wrap_val_seen", ok, 1);
        @(negedge sys_clk);
        digest_ready = 1'b0;
        chk("stat_cnt_wrap", digest_cnt, 16'h0000);
`endif

        chk("no_pop_while_empty", underflow, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
